// File: rtl/forwarding_control.sv
`default_nettype none
// ============================================================================
// Module      : forwarding_control
// Description : Operand-forwarding and load-use hazard controller for a
//               5-stage MIPS pipeline. Shadows the destination register and
//               write/load flags of the EX and MEM instructions, registers the
//               EX-stage operand mux selects one cycle ahead, and stalls
//               PC / IF-ID for one cycle on a load-use dependency.
// Revision    : 1.0 - initial release
// ============================================================================
module forwarding_control #(
    parameter int NB_REG = 5,
    parameter int NB_SEL = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic [NB_REG-1:0] id_rs_i,
    input  logic [NB_REG-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [NB_REG-1:0] id_rd_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    output logic [NB_SEL-1:0] fwd_a_sel_o,
    output logic [NB_SEL-1:0] fwd_b_sel_o,
    output logic              stall_o,
    output logic              pc_write_o,
    output logic              ifid_write_o
);

    // Operand mux select codes
    localparam logic [NB_SEL-1:0] SEL_RF    = NB_SEL'(0);
    localparam logic [NB_SEL-1:0] SEL_MEMWB = NB_SEL'(1);
    localparam logic [NB_SEL-1:0] SEL_EXMEM = NB_SEL'(2);
    localparam logic [NB_REG-1:0] REG_ZERO  = '0;

    // Shadow of the instruction currently in EX
    logic [NB_REG-1:0] ex_rd;
    logic              ex_wr;
    logic              ex_mr;
    // Shadow of the instruction currently in MEM
    logic [NB_REG-1:0] mem_rd;
    logic              mem_wr;

    logic              hit_rs;
    logic              hit_rt;
    logic              load_in_ex;
    logic [NB_SEL-1:0] next_a_sel;
    logic [NB_SEL-1:0] next_b_sel;

    // Select for one source operand; the younger producer (EX) wins over MEM.
    function automatic logic [NB_SEL-1:0] lookahead(
        input logic [NB_REG-1:0] src,
        input logic              used,
        input logic [NB_REG-1:0] e_rd,
        input logic              e_wr,
        input logic [NB_REG-1:0] m_rd,
        input logic              m_wr
    );
        logic [NB_SEL-1:0] sel;
        sel = SEL_RF;
        if (used && (src != REG_ZERO)) begin
            if (e_wr && (e_rd == src)) begin
                sel = SEL_EXMEM;
            end else if (m_wr && (m_rd == src)) begin
                sel = SEL_MEMWB;
            end
        end
        return sel;
    endfunction

    // Load-use detection and next-cycle select computation
    always_comb begin
        load_in_ex   = ex_mr & ex_wr & (ex_rd != REG_ZERO);
        hit_rs       = id_use_rs_i & (id_rs_i == ex_rd);
        hit_rt       = id_use_rt_i & (id_rt_i == ex_rd);
        stall_o      = load_in_ex & (hit_rs | hit_rt);
        pc_write_o   = enable_i & ~stall_o;
        ifid_write_o = enable_i & ~stall_o;
        next_a_sel   = lookahead(id_rs_i, id_use_rs_i, ex_rd, ex_wr, mem_rd, mem_wr);
        next_b_sel   = lookahead(id_rt_i, id_use_rt_i, ex_rd, ex_wr, mem_rd, mem_wr);
    end

    // Shadow pipeline advance, bubble injection on stall, select registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ex_rd       <= '0;
            ex_wr       <= 1'b0;
            ex_mr       <= 1'b0;
            mem_rd      <= '0;
            mem_wr      <= 1'b0;
            fwd_a_sel_o <= SEL_RF;
            fwd_b_sel_o <= SEL_RF;
        end else if (enable_i) begin
            mem_rd <= ex_rd;
            mem_wr <= ex_wr;
            if (stall_o) begin
                ex_rd       <= '0;
                ex_wr       <= 1'b0;
                ex_mr       <= 1'b0;
                fwd_a_sel_o <= SEL_RF;
                fwd_b_sel_o <= SEL_RF;
            end else begin
                ex_rd       <= id_rd_i;
                ex_wr       <= id_reg_write_i;
                ex_mr       <= id_mem_read_i;
                fwd_a_sel_o <= next_a_sel;
                fwd_b_sel_o <= next_b_sel;
            end
        end
    end

endmodule
`default_nettype wire
